// File: rtl/hardroc_data_receiver.sv
// -----------------------------------------------------------------------------
// hardroc_data_receiver
//
// Deserialises the HARDROC readout stream that follows each StartReadout.
// Bits arrive on DOUT (active low) inside the TRANSMITON window (active low).
// Each bit is taken on a SampleEn strobe. The bits are packed MSB-first into
// 16-bit words, and each word is written to the USB-side data FIFO. When the
// acquisition run is over (AllDone) and the receiver is idle, DataTransmitDone
// is returned to the DAQ control stage.
//
// Optional build macro: HARDROC_HEADER_TRAILER_EN
//   defined   : each frame is 16'hFFAB, data words, 16'hFF45, word count
//   undefined : only the data words are written
//
// Ports
//   Clk               system clock, rising edge
//   reset_n           asynchronous active-low reset
//   DOUT              ASIC serial data, active low, asynchronous
//   TRANSMITON        ASIC transmit window, active low, asynchronous
//   SampleEn          one-Clk strobe per readout bit
//   StartReadout      rising edge arms one frame
//   AllDone           acquisition run finished (level)
//   ExternalFifoFull  USB data FIFO full
//   ParallelData      word to FIFO, held until the next write
//   ParallelDataValid one-Clk FIFO write strobe
//   DataTransmitDone  level to DAQ control
//   Overflow          sticky; a data word was dropped in the current frame
// -----------------------------------------------------------------------------
module hardroc_data_receiver (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        DOUT,
  input  logic        TRANSMITON,
  input  logic        SampleEn,
  input  logic        StartReadout,
  input  logic        AllDone,
  input  logic        ExternalFifoFull,
  output logic [15:0] ParallelData,
  output logic        ParallelDataValid,
  output logic        DataTransmitDone,
  output logic        Overflow
);

`ifdef HARDROC_HEADER_TRAILER_EN
  localparam logic [15:0] HEADER_WORD  = 16'hFFAB;
  localparam logic [15:0] TRAILER_WORD = 16'hFF45;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    HEADER        = 3'd1,
    WAIT_TRANSMIT = 3'd2,
    RECEIVE       = 3'd3,
    FLUSH         = 3'd4,
    TRAILER       = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WAIT_TRANSMIT = 3'd2,
    RECEIVE       = 3'd3,
    FLUSH         = 3'd4
  } state_t;
`endif

  state_t      state;
  logic [3:0]  bitCount;
  logic [15:0] wordCount;
  logic [15:0] shiftReg;
`ifdef HARDROC_HEADER_TRAILER_EN
  logic        trailerPhase;
`endif

  // Synchroniser and edge-detect registers
  logic doutSync_p0, doutSync_p1;
  logic txSync_p0, txSync_p1, txSync_p2;
  logic startReg_p0, startReg_p1;

  logic        dataBit;
  logic        txActive;
  logic        txRise;
  logic        startRise;
  logic [15:0] shiftNext;

  // Pads the partial word on the LSB side so its first bit sits at bit 15.
  // Only called with count in 1..15.
  function automatic logic [15:0] leftJustify(input logic [15:0] word,
                                              input logic [3:0]  count);
    logic [4:0] shamt;
    shamt = 5'd16 - {1'b0, count};
    return word << shamt;
  endfunction

  // Word counter that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] satInc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  // ---- stage p0/p1: input synchronisers (idle level of the ASIC lines is 1)
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      doutSync_p0 <= 1'b1;
      doutSync_p1 <= 1'b1;
      txSync_p0   <= 1'b1;
      txSync_p1   <= 1'b1;
      txSync_p2   <= 1'b1;
      startReg_p0 <= 1'b0;
      startReg_p1 <= 1'b0;
    end else begin
      doutSync_p0 <= DOUT;
      doutSync_p1 <= doutSync_p0;
      txSync_p0   <= TRANSMITON;
      txSync_p1   <= txSync_p0;
      txSync_p2   <= txSync_p1;
      startReg_p0 <= StartReadout;
      startReg_p1 <= startReg_p0;
    end
  end

  assign dataBit   = ~doutSync_p1;
  assign txActive  = ~txSync_p1;
  // Window closing: synced TRANSMITON goes from 0 to 1.
  assign txRise    = txSync_p1 & ~txSync_p2;
  assign startRise = startReg_p0 & ~startReg_p1;
  assign shiftNext = {shiftReg[14:0], dataBit};

  // ---- stage p2: frame control, deserialiser and FIFO write port
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      bitCount          <= 4'd0;
      wordCount         <= 16'd0;
      shiftReg          <= 16'd0;
      ParallelData      <= 16'h0000;
      ParallelDataValid <= 1'b0;
      DataTransmitDone  <= 1'b0;
      Overflow          <= 1'b0;
`ifdef HARDROC_HEADER_TRAILER_EN
      trailerPhase      <= 1'b0;
`endif
    end else begin
      ParallelDataValid <= 1'b0;
      DataTransmitDone  <= 1'b0;

      case (state)
        IDLE: begin
          DataTransmitDone <= AllDone;
          if (startRise) begin
            Overflow  <= 1'b0;
            wordCount <= 16'd0;
            bitCount  <= 4'd0;
            shiftReg  <= 16'd0;
`ifdef HARDROC_HEADER_TRAILER_EN
            state     <= HEADER;
`else
            state     <= WAIT_TRANSMIT;
`endif
          end
        end

`ifdef HARDROC_HEADER_TRAILER_EN
        HEADER: begin
          if (!ExternalFifoFull) begin
            ParallelData      <= HEADER_WORD;
            ParallelDataValid <= 1'b1;
            state             <= WAIT_TRANSMIT;
          end
        end
`endif

        WAIT_TRANSMIT: begin
          if (txActive) begin
            state <= RECEIVE;
          end
        end

        RECEIVE: begin
          // A strobe coinciding with the window closing is not a data bit:
          // txRise implies synced TRANSMITON is already high.
          if (txRise) begin
            state <= FLUSH;
          end else if (SampleEn && txActive) begin
            shiftReg <= shiftNext;
            bitCount <= bitCount + 4'd1;
            if (bitCount == 4'd15) begin
              if (!ExternalFifoFull) begin
                ParallelData      <= shiftNext;
                ParallelDataValid <= 1'b1;
                wordCount         <= satInc(wordCount);
              end else begin
                Overflow <= 1'b1;
              end
            end
          end
        end

        FLUSH: begin
          // First pass writes any partial word, second pass leaves.
          if (bitCount != 4'd0) begin
            bitCount <= 4'd0;
            if (!ExternalFifoFull) begin
              ParallelData      <= leftJustify(shiftReg, bitCount);
              ParallelDataValid <= 1'b1;
              wordCount         <= satInc(wordCount);
            end else begin
              Overflow <= 1'b1;
            end
          end else begin
`ifdef HARDROC_HEADER_TRAILER_EN
            trailerPhase <= 1'b0;
            state        <= TRAILER;
`else
            state        <= IDLE;
`endif
          end
        end

`ifdef HARDROC_HEADER_TRAILER_EN
        TRAILER: begin
          if (!ExternalFifoFull) begin
            ParallelDataValid <= 1'b1;
            if (!trailerPhase) begin
              ParallelData <= TRAILER_WORD;
              trailerPhase <= 1'b1;
            end else begin
              ParallelData <= wordCount;
              trailerPhase <= 1'b0;
              state        <= IDLE;
            end
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hardroc_data_receiver.sv
module tb_hardroc_data_receiver;

  logic        Clk = 1'b0;
  logic        reset_n;
  logic        DOUT;
  logic        TRANSMITON;
  logic        SampleEn;
  logic        StartReadout;
  logic        AllDone;
  logic        ExternalFifoFull;
  logic [15:0] ParallelData;
  logic        ParallelDataValid;
  logic        DataTransmitDone;
  logic        Overflow;

  int checks = 0;
  int errors = 0;

  logic [15:0] writes[$];

  hardroc_data_receiver dut (
    .Clk              (Clk),
    .reset_n          (reset_n),
    .DOUT             (DOUT),
    .TRANSMITON       (TRANSMITON),
    .SampleEn         (SampleEn),
    .StartReadout     (StartReadout),
    .AllDone          (AllDone),
    .ExternalFifoFull (ExternalFifoFull),
    .ParallelData     (ParallelData),
    .ParallelDataValid(ParallelDataValid),
    .DataTransmitDone (DataTransmitDone),
    .Overflow         (Overflow)
  );

  always #5 Clk = ~Clk;

  // Every cycle with the write strobe high is one FIFO write.
  always @(negedge Clk) begin
    if (ParallelDataValid === 1'b1) writes.push_back(ParallelData);
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expectWord(input string tag, input logic [15:0] exp);
    if (writes.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed no write expected %h", tag, exp);
    end else begin
      chk(tag, {16'h0, writes.pop_front()}, {16'h0, exp});
    end
  endtask

  task automatic expectNone(input string tag);
    chk(tag, writes.size(), 0);
  endtask

  // DOUT is synchronised, SampleEn is not: hold the bit 2 Clk before the strobe.
  task automatic sendBit(input logic b);
    DOUT = ~b;
    tick;
    tick;
    SampleEn = 1'b1;
    tick;
    SampleEn = 1'b0;
  endtask

  task automatic sendWord(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) sendBit(w[i]);
  endtask

  task automatic beginFrame;
    StartReadout = 1'b1;
    repeat (3) tick;
    StartReadout = 1'b0;
    TRANSMITON = 1'b0;
    repeat (4) tick;
  endtask

  task automatic endFrame;
    DOUT = 1'b1;
    TRANSMITON = 1'b1;
    repeat (12) tick;
  endtask

  initial begin
    reset_n = 1'b0;
    DOUT = 1'b1;
    TRANSMITON = 1'b1;
    SampleEn = 1'b0;
    StartReadout = 1'b0;
    AllDone = 1'b0;
    ExternalFifoFull = 1'b0;
    #2;
    chk("rst_data", {16'h0, ParallelData}, 32'h0);
    chk("rst_valid", ParallelDataValid, 0);
    chk("rst_done", DataTransmitDone, 0);
    chk("rst_ovf", Overflow, 0);
    repeat (3) tick;
    reset_n = 1'b1;
    repeat (2) tick;
    chk("idle_state", 32'(dut.state), 0);

    // Two full words
    beginFrame;
    sendWord(16'hA5A5, 16);
    sendWord(16'h1234, 16);
    endFrame;
`ifdef HARDROC_HEADER_TRAILER_EN
    expectWord("t1_hdr", 16'hFFAB);
`endif
    expectWord("t1_w0", 16'hA5A5);
    expectWord("t1_w1", 16'h1234);
`ifdef HARDROC_HEADER_TRAILER_EN
    expectWord("t1_trl", 16'hFF45);
    expectWord("t1_cnt", 16'h0002);
    chk("t1_hold", {16'h0, ParallelData}, 32'h0002);
`else
    chk("t1_hold", {16'h0, ParallelData}, 32'h1234);
`endif
    expectNone("t1_extra");
    chk("t1_ovf", Overflow, 0);
    chk("t1_wcnt", {16'h0, dut.wordCount}, 32'd2);

    // Full word plus a 4-bit remainder flushed left-justified
    beginFrame;
    sendWord(16'hBEEF, 16);
    sendWord(16'h000A, 4);
    endFrame;
`ifdef HARDROC_HEADER_TRAILER_EN
    expectWord("t2_hdr", 16'hFFAB);
`endif
    expectWord("t2_w0", 16'hBEEF);
    expectWord("t2_flush", 16'hA000);
`ifdef HARDROC_HEADER_TRAILER_EN
    expectWord("t2_trl", 16'hFF45);
    expectWord("t2_cnt", 16'h0002);
`endif
    expectNone("t2_extra");
    chk("t2_wcnt", {16'h0, dut.wordCount}, 32'd2);

    // FIFO full while the second word completes: word dropped
    beginFrame;
    sendWord(16'h1111, 16);
    ExternalFifoFull = 1'b1;
    sendWord(16'h2222, 16);
    ExternalFifoFull = 1'b0;
    endFrame;
`ifdef HARDROC_HEADER_TRAILER_EN
    expectWord("t3_hdr", 16'hFFAB);
`endif
    expectWord("t3_w0", 16'h1111);
`ifdef HARDROC_HEADER_TRAILER_EN
    expectWord("t3_trl", 16'hFF45);
    expectWord("t3_cnt", 16'h0001);
`endif
    expectNone("t3_extra");
    chk("t3_ovf", Overflow, 1);
    chk("t3_wcnt", {16'h0, dut.wordCount}, 32'd1);

    // Frame armed with the FIFO full for 10 Clk; next start clears Overflow
    ExternalFifoFull = 1'b1;
    StartReadout = 1'b1;
    repeat (10) tick;
    expectNone("t4_stall");
    chk("t4_ovf_clr", Overflow, 0);
    ExternalFifoFull = 1'b0;
    StartReadout = 1'b0;
    tick;
    TRANSMITON = 1'b0;
    repeat (4) tick;
    sendWord(16'h5A5A, 16);
    endFrame;
`ifdef HARDROC_HEADER_TRAILER_EN
    expectWord("t4_hdr", 16'hFFAB);
`endif
    expectWord("t4_w0", 16'h5A5A);
`ifdef HARDROC_HEADER_TRAILER_EN
    expectWord("t4_trl", 16'hFF45);
    expectWord("t4_cnt", 16'h0001);
`endif
    expectNone("t4_extra");

    // DataTransmitDone follows AllDone by one Clk in IDLE
    AllDone = 1'b1;
    chk("t5_done_pre", DataTransmitDone, 0);
    tick;
    chk("t5_done_hi", DataTransmitDone, 1);
    AllDone = 1'b0;
    tick;
    chk("t5_done_lo", DataTransmitDone, 0);

    // Reset in the middle of a word
    beginFrame;
    sendWord(16'h00FF, 8);
    reset_n = 1'b0;
    #1;
    chk("t6_valid", ParallelDataValid, 0);
    chk("t6_data", {16'h0, ParallelData}, 32'h0);
    chk("t6_state", 32'(dut.state), 0);
    chk("t6_bits", {28'h0, dut.bitCount}, 32'h0);
    DOUT = 1'b1;
    TRANSMITON = 1'b1;
    tick;
    reset_n = 1'b1;
`ifdef HARDROC_HEADER_TRAILER_EN
    expectWord("t6_hdr", 16'hFFAB);
`endif
    repeat (20) tick;
    expectNone("t6_stale");
    chk("t6_idle", 32'(dut.state), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
